data_mem_mmio: RTL and testbench
================================

# data_mem_mmio

Data-side memory responder for the single-cycle RISC-V core. It answers the core's data port: address = ALU result, write data, write enable, and a combinational read-data return. It holds a word-addressed RAM plus a small memory-mapped I/O window with a cycle counter, a compare/match flag, a GPIO register and a console TX FIFO drained by an external consumer. It sits beside the core at top level, wired to the core's ALUResult, WriteData, MemWrite and ReadData.

## Interface
- DEPTH_WORDS, 64: RAM size in 32-bit words; power of 2.
- FIFO_DEPTH, 4: console FIFO entries; power of 2, at most 8.
- CLK_DM  in  1: clock; all state updates on the rising edge.
- reset_DM  in  1: reset, synchronous, active-high.
- A_DM  in  32: byte address from the core's ALU result. A[1:0] is ignored; access is word-only.
- WD_DM  in  32: write data.
- WE_DM  in  1: write enable.
- RD_DM  out  32: read data, combinational from A_DM and the current state.
- gpio_DM  out  32: GPIO register.
- cons_data_DM  out  8: FIFO head byte.
- cons_valid_DM  out  1: FIFO not empty.
- cons_ready_DM  in  1: consumer accepts the head byte.

## Operation
- **Decode**
  - MMIO is selected when A[31:8] == 24'hFFFFFF.
  - Otherwise the access goes to RAM at index A[log2(DEPTH_WORDS)+1:2]. Higher address bits alias.
- **RAM**
  - A write at the edge stores WD when WE=1.
  - Reset does not change RAM contents.
- **MMIO offsets (A[7:0])**
  - 0x00 GPIO: read/write.
  - 0x04 CYCLE_LO: read-only, counter[31:0].
  - 0x08 CYCLE_HI: read-only, counter[63:32].
  - 0x0C CMP: read/write.
  - 0x10 STATUS:
    - bit0 match, bit1 full, bit2 empty, bit3 overflow, bits[7:4] count (zero-extended); all other bits read 0.
    - A write with WD bit0=1 clears match; WD bit3=1 clears overflow.
  - 0x14 CONSOLE: write-only. A write pushes WD[7:0]. Reads return 0.
  - Any other offset reads 0; writes to it are ignored.
- **Reads have no side effects.** A_DM is driven every cycle whether or not the instruction is a load.
- **Cycle counter**
  - 64-bit; increments by 1 every non-reset cycle and wraps to 0.
  - It is not writable.
- **Match flag**
  - Set at an edge when the pre-increment CYCLE_LO equals CMP.
  - If set and a W1C happen at the same edge, set wins.
- **Console FIFO**
  - Push: a CONSOLE write while not full.
  - A push while full is dropped and sets overflow.
  - Pop: cons_valid_DM && cons_ready_DM.
  - Push and pop at the same edge:
    - When full: the pop frees an entry, the push is accepted, count is unchanged, and overflow is not set.
    - When empty: no pop occurs (valid=0) and the push is accepted.
  - cons_data_DM is the head entry. It is don't-care when empty.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- **Reset values** (reset_DM high at an edge): gpio 0, CMP 0, counter 0, match 0, overflow 0, FIFO empty (count 0, cons_valid_DM 0), RD_DM per decode of the reset state.
- **Read latency:** 0 cycles, combinational. A write at edge n is visible on RD_DM from cycle n+1. A same-cycle read of the address being written returns the old value.
- **Counter visibility:** the counter reads 0 in the first cycle after reset and k after k non-reset edges.
- **FIFO latency:** a byte pushed at edge n shows cons_valid_DM=1 from cycle n+1, with no fall-through.
- **Reset mid-operation:** reset overrides all same-edge writes, pushes and pops. FIFO contents are discarded.

## Structure
- Package dmem_pkg holds:
  - MMIO base (24'hFFFFFF);
  - offset constants GPIO/CYCLE_LO/CYCLE_HI/CMP/STATUS/CONSOLE;
  - STATUS bit positions.
- Sub-module console_fifo (parameter FIFO_DEPTH, width 8):
  - inputs push/pop/din;
  - outputs dout/full/empty/count/overflow_set.
- RAM, decode, counter, compare and GPIO stay in the top level.

## Test plan
- RAM write then read: write 0xDEADBEEF to 0x00000010, then read 0x00000010 → RD=0xDEADBEEF. Read 0x00000010+4·DEPTH_WORDS → same value (alias). Reset, then read 0x00000010 → still 0xDEADBEEF.
- Counter and match:
  - After reset, CYCLE_LO=0; after 5 idle cycles it reads 5.
  - Write CMP=20; STATUS bit0 becomes 1 after the edge where the counter is 20.
  - Write STATUS=1 → bit0 reads 0; W1C at the edge where counter==CMP → bit0 stays 1.
- FIFO fill and overflow: with cons_ready_DM=0, push 'A','B','C','D','E' → STATUS full=1, count=4, overflow=1. Then ready=1 → drains 'A','B','C','D' over 4 cycles, then empty=1.
- Full with simultaneous push and pop: FIFO full with ready=1, push 'X' → count stays 4, overflow stays 0, 'X' arrives last.
- GPIO and unmapped: write 0x5A to 0xFFFFFF00 → gpio_DM=0x5A. Write to 0xFFFFFF40 → no change, reads 0. CONSOLE reads 0.
- Reset mid-operation: reset asserted at the same edge as a push and a GPIO write → FIFO empty, gpio_DM=0, counter 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory responder: MMIO window base,
// register offsets and STATUS bit positions.
package dmem_pkg;

    localparam logic [23:0] MMIO_BASE = 24'hFFFFFF;

    // Byte offsets inside the MMIO window; decode compares them with A[1:0] forced to zero
    localparam logic [7:0] OFF_GPIO     = 8'h00;
    localparam logic [7:0] OFF_CYCLE_LO = 8'h04;
    localparam logic [7:0] OFF_CYCLE_HI = 8'h08;
    localparam logic [7:0] OFF_CMP      = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_CONSOLE  = 8'h14;

    // STATUS register layout
    localparam int unsigned ST_MATCH     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_OVERFLOW  = 3;
    localparam int unsigned ST_COUNT_LSB = 4;
    localparam int unsigned ST_COUNT_MSB = 7;

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the console consumer. Head entry is presented directly
// (no fall-through); a push while full is accepted only if a pop frees a slot.
module console_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow_set
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    store [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign dout  = store[rd_ptr];

    // A pop only happens with data present; a pop at full makes room for a same-edge push
    assign do_pop       = pop && !empty;
    assign do_push      = push && (!full || do_pop);
    assign overflow_set = push && !do_push;

    // Entry storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-port responder for the single-cycle core: word RAM plus an MMIO window
// holding GPIO, a 64-bit cycle counter, a compare/match flag and a console FIFO.
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        CLK_DM,
    input  logic        reset_DM,
    input  logic [31:0] A_DM,
    input  logic [31:0] WD_DM,
    input  logic        WE_DM,
    output logic [31:0] RD_DM,
    output logic [31:0] gpio_DM,
    output logic [7:0]  cons_data_DM,
    output logic        cons_valid_DM,
    input  logic        cons_ready_DM
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    logic [7:0]    off;
    logic          wr_mmio;
    logic          wr_gpio;
    logic          wr_cmp;
    logic          wr_status;
    logic          wr_console;

    logic [63:0]   cycle_cnt;
    logic [31:0]   cmp_reg;
    logic [31:0]   gpio_reg;
    logic          match_flag;
    logic          overflow_flag;
    logic [31:0]   status_word;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_ovf_set;

    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^A_DM[1:0];

    assign is_mmio    = (A_DM[31:8] == MMIO_BASE);
    assign off        = {A_DM[7:2], 2'b00};
    assign ram_idx    = A_DM[AW+1:2];
    assign wr_mmio    = WE_DM && is_mmio;
    assign wr_gpio    = wr_mmio && (off == OFF_GPIO);
    assign wr_cmp     = wr_mmio && (off == OFF_CMP);
    assign wr_status  = wr_mmio && (off == OFF_STATUS);
    assign wr_console = wr_mmio && (off == OFF_CONSOLE);

    assign gpio_DM       = gpio_reg;
    assign cons_valid_DM = !fifo_empty;

    console_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_console_fifo (
        .clk          (CLK_DM),
        .reset        (reset_DM),
        .push         (wr_console),
        .pop          (cons_ready_DM),
        .din          (WD_DM[7:0]),
        .dout         (cons_data_DM),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .overflow_set (fifo_ovf_set)
    );

    // RAM write port; contents survive reset but a reset edge still blocks the write
    always_ff @(posedge CLK_DM) begin
        if (WE_DM && !is_mmio && !reset_DM) begin
            ram[ram_idx] <= WD_DM;
        end
    end

    // Counter, compare, GPIO and sticky flags; setting a flag wins over a same-edge clear
    always_ff @(posedge CLK_DM) begin
        if (reset_DM) begin
            cycle_cnt     <= '0;
            cmp_reg       <= '0;
            gpio_reg      <= '0;
            match_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (wr_gpio) begin
                gpio_reg <= WD_DM;
            end
            if (wr_cmp) begin
                cmp_reg <= WD_DM;
            end
            if (cycle_cnt[31:0] == cmp_reg) begin
                match_flag <= 1'b1;
            end else if (wr_status && WD_DM[ST_MATCH]) begin
                match_flag <= 1'b0;
            end
            if (fifo_ovf_set) begin
                overflow_flag <= 1'b1;
            end else if (wr_status && WD_DM[ST_OVERFLOW]) begin
                overflow_flag <= 1'b0;
            end
        end
    end

    // STATUS register assembly
    always_comb begin
        status_word                             = '0;
        status_word[ST_MATCH]                   = match_flag;
        status_word[ST_FULL]                    = fifo_full;
        status_word[ST_EMPTY]                   = fifo_empty;
        status_word[ST_OVERFLOW]                = overflow_flag;
        status_word[ST_COUNT_MSB:ST_COUNT_LSB]  = 4'(fifo_count);
    end

    // Combinational read-data mux; reads never change state
    always_comb begin
        RD_DM = '0;
        if (is_mmio) begin
            case (off)
                OFF_GPIO:     RD_DM = gpio_reg;
                OFF_CYCLE_LO: RD_DM = cycle_cnt[31:0];
                OFF_CYCLE_HI: RD_DM = cycle_cnt[63:32];
                OFF_CMP:      RD_DM = cmp_reg;
                OFF_STATUS:   RD_DM = status_word;
                default:      RD_DM = '0;
            endcase
        end else begin
            RD_DM = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios followed by
// random traffic, all compared against a behavioural model of the memory map.
module tb_data_mem_mmio;

    localparam int unsigned DW = 64;
    localparam int unsigned FD = 4;
    localparam logic [31:0] MB = 32'hFFFFFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
    logic [31:0] gpio;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0]     m_ram [DW];
    bit              m_ramv [DW];
    longint unsigned m_cnt;
    logic [31:0]     m_cmp;
    logic [31:0]     m_gpio;
    bit              m_match;
    bit              m_ovf;
    byte unsigned    m_q[$];
    bit              m_known = 1'b0;

    // Values seen during the most recent cycle
    logic [31:0] rd_seen;
    logic [7:0]  data_seen;
    logic        valid_seen;

    data_mem_mmio #(
        .DEPTH_WORDS(DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK_DM       (clk),
        .reset_DM     (reset),
        .A_DM         (addr),
        .WD_DM        (wdata),
        .WE_DM        (we),
        .RD_DM        (rd),
        .gpio_DM      (gpio),
        .cons_data_DM (cons_data),
        .cons_valid_DM(cons_valid),
        .cons_ready_DM(cons_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        logic [7:0] o;
        int unsigned idx;
        known = 1'b1;
        if (a[31:8] == 24'hFFFFFF) begin
            o = a[7:0] & 8'hFC;
            case (o)
                8'h00: return m_gpio;
                8'h04: return m_cnt[31:0];
                8'h08: return m_cnt[63:32];
                8'h0C: return m_cmp;
                8'h10: return {24'd0, 4'(m_q.size()), m_ovf, (m_q.size() == 0),
                               (m_q.size() == FD), m_match};
                default: return 32'd0;
            endcase
        end
        idx = (a >> 2) % DW;
        known = m_ramv[idx];
        return m_ram[idx];
    endfunction

    // One clock: drive at negedge, check combinational outputs, then advance the model at posedge
    task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                       input logic w, input logic rdy);
        logic [31:0] exp_rd;
        bit          known;
        bit          mmio;
        logic [7:0]  o;
        bit          pop;
        bit          push;
        bit          w1c;
        int unsigned idx;
        @(negedge clk);
        reset = rst; addr = a; wdata = wd; we = w; cons_ready = rdy;
        #1;
        rd_seen = rd; data_seen = cons_data; valid_seen = cons_valid;
        if (m_known) begin
            exp_rd = model_read(a, known);
            if (known) check("rd", rd, exp_rd);
            check("gpio", gpio, m_gpio);
            check("cons_valid", {31'd0, cons_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) check("cons_data", {24'd0, cons_data}, {24'd0, m_q[0]});
        end
        @(posedge clk);
        mmio = (a[31:8] == 24'hFFFFFF);
        o    = a[7:0] & 8'hFC;
        if (rst) begin
            m_cnt = 0; m_cmp = 0; m_gpio = 0; m_match = 0; m_ovf = 0;
            m_q.delete();
            m_known = 1'b1;
        end else begin
            pop  = rdy && (m_q.size() > 0);
            push = w && mmio && (o == 8'h14);
            w1c  = w && mmio && (o == 8'h10);
            if (m_cnt[31:0] == m_cmp) m_match = 1;
            else if (w1c && wd[0]) m_match = 0;
            if (push && m_q.size() == FD && !pop) m_ovf = 1;
            else if (w1c && wd[3]) m_ovf = 0;
            if (pop) void'(m_q.pop_front());
            if (push && m_q.size() < FD) m_q.push_back(wd[7:0]);
            if (w && mmio && o == 8'h00) m_gpio = wd;
            if (w && mmio && o == 8'h0C) m_cmp = wd;
            if (w && !mmio) begin
                idx = (a >> 2) % DW;
                m_ram[idx] = wd;
                m_ramv[idx] = 1'b1;
            end
            m_cnt++;
        end
    endtask

    task automatic rd_cyc(input logic [31:0] a, input logic rdy);
        cyc(1'b0, a, 32'd0, 1'b0, rdy);
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        cyc(1'b0, a, wd, 1'b1, rdy);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        byte unsigned exp_b;
        string        msg;
        int unsigned  sel;

        foreach (m_ramv[i]) m_ramv[i] = 1'b0;
        reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; cons_ready = 1'b0;

        cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        rd_cyc(MB | 32'h10, 1'b0);
        check("reset_status", rd_seen, 32'h0000_0004);

        // RAM write, alias read, survival across reset
        wr_cyc(32'h10, 32'hDEADBEEF, 1'b0);
        rd_cyc(32'h10, 1'b0);
        check("ram_read", rd_seen, 32'hDEADBEEF);
        rd_cyc(32'h10 + 4 * DW, 1'b0);
        check("ram_alias", rd_seen, 32'hDEADBEEF);
        cyc(1'b1, 32'h10, 32'd0, 1'b0, 1'b0);
        rd_cyc(32'h10, 1'b0);
        check("ram_keep", rd_seen, 32'hDEADBEEF);

        // Counter: reads 0 right after reset and 5 after five more edges
        cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        rd_cyc(MB | 32'h04, 1'b0);
        check("cnt_zero", rd_seen, 32'd0);
        for (int i = 0; i < 5; i++) rd_cyc(MB | 32'h04, 1'b0);
        check("cnt_five", rd_seen, 32'd5);

        // Match flag: set when the counter hits CMP
        wr_cyc(MB | 32'h0C, 32'd20, 1'b0);
        wr_cyc(MB | 32'h10, 32'd1, 1'b0);
        for (int i = 0; i < 40 && m_cnt <= 20; i++) rd_cyc(MB | 32'h10, 1'b0);
        rd_cyc(MB | 32'h10, 1'b0);
        check("match_set", {31'd0, rd_seen[0]}, 32'd1);
        wr_cyc(MB | 32'h10, 32'd1, 1'b0);
        rd_cyc(MB | 32'h10, 1'b0);
        check("match_w1c", {31'd0, rd_seen[0]}, 32'd0);
        wr_cyc(MB | 32'h0C, m_cnt[31:0] + 32'd2, 1'b0);
        rd_cyc(MB | 32'h10, 1'b0);
        wr_cyc(MB | 32'h10, 32'd1, 1'b0);
        rd_cyc(MB | 32'h10, 1'b0);
        check("match_set_wins", {31'd0, rd_seen[0]}, 32'd1);

        // FIFO fill past capacity, then drain
        cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        msg = "ABCDE";
        for (int i = 0; i < 5; i++) wr_cyc(MB | 32'h14, {24'd0, msg[i]}, 1'b0);
        rd_cyc(MB | 32'h10, 1'b0);
        check("fifo_full_ovf", {24'd0, rd_seen[7:1], 1'b0}, 32'h0000_004A);
        for (int i = 0; i < 4; i++) begin
            exp_b = msg[i];
            rd_cyc(32'h0, 1'b1);
            check("drain_byte", {24'd0, data_seen}, {24'd0, exp_b});
        end
        rd_cyc(MB | 32'h10, 1'b1);
        check("fifo_empty", {31'd0, rd_seen[2]}, 32'd1);

        // Full FIFO with push and pop at the same edge
        wr_cyc(MB | 32'h10, 32'h8, 1'b0);
        msg = "PQRS";
        for (int i = 0; i < 4; i++) wr_cyc(MB | 32'h14, {24'd0, msg[i]}, 1'b0);
        wr_cyc(MB | 32'h14, 32'h58, 1'b1);
        rd_cyc(MB | 32'h10, 1'b0);
        check("full_pushpop", {24'd0, rd_seen[7:1], 1'b0}, 32'h0000_0042);
        for (int i = 0; i < 4; i++) rd_cyc(32'h0, 1'b1);
        check("x_last", {24'd0, data_seen}, 32'h58);

        // GPIO, unmapped offset, write-only console
        wr_cyc(MB | 32'h00, 32'h5A, 1'b0);
        wr_cyc(MB | 32'h40, 32'hFFFF_FFFF, 1'b0);
        check("gpio_set", gpio, 32'h5A);
        rd_cyc(MB | 32'h40, 1'b0);
        check("unmapped_rd", rd_seen, 32'd0);
        check("gpio_kept", gpio, 32'h5A);
        rd_cyc(MB | 32'h14, 1'b1);
        check("console_rd", rd_seen, 32'd0);

        // Reset overriding a push and a GPIO write
        wr_cyc(MB | 32'h14, 32'h31, 1'b0);
        cyc(1'b1, MB | 32'h14, 32'h32, 1'b1, 1'b0);
        cyc(1'b1, MB | 32'h00, 32'h77, 1'b1, 1'b1);
        rd_cyc(MB | 32'h04, 1'b0);
        check("rst_cnt", rd_seen, 32'd0);
        check("rst_gpio", gpio, 32'd0);
        check("rst_valid", {31'd0, valid_seen}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                a = $urandom;
                if (a[31:8] == 24'hFFFFFF) a[31] = 1'b0;
            end else begin
                case ($urandom_range(0, 6))
                    0: a = MB | 32'h00;
                    1: a = MB | 32'h04;
                    2: a = MB | 32'h08;
                    3: a = MB | 32'h0C;
                    4: a = MB | 32'h10;
                    5: a = MB | 32'h14;
                    default: a = MB | {24'd0, 8'($urandom)};
                endcase
                a[1:0] = 2'($urandom);
            end
            wd = $urandom;
            if ((a[31:8] == 24'hFFFFFF) && ((a[7:0] & 8'hFC) == 8'h0C))
                wd = m_cnt[31:0] + $urandom_range(0, 4);
            cyc(($urandom_range(0, 63) == 0), a, wd, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
